// File: rtl/frame_mem_arbiter_if.sv
// Bundles the display, blur-engine and RAM-side signals of the frame buffer arbiter.
// Latency: none (wiring only).
// Backpressure: the blur engine holds its request until proc_gnt; display requests are never held.
interface frame_mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 24,
    parameter int CNT_W  = 16
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              disp_miss;
    logic              proc_req;
    logic              proc_we;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_wdata;
    logic              proc_gnt;
    logic [DATA_W-1:0] proc_rdata;
    logic              proc_rvalid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  miss_count;

    // Arbiter side
    modport slave (
        input  disp_req, disp_addr, proc_req, proc_we, proc_addr, proc_wdata, mem_rdata,
        output disp_data, disp_valid, disp_miss, proc_gnt, proc_rdata, proc_rvalid,
               mem_en, mem_we, mem_addr, mem_wdata, miss_count
    );

    // Environment side: both masters plus the RAM
    modport master (
        output disp_req, disp_addr, proc_req, proc_we, proc_addr, proc_wdata, mem_rdata,
        input  disp_data, disp_valid, disp_miss, proc_gnt, proc_rdata, proc_rvalid,
               mem_en, mem_we, mem_addr, mem_wdata, miss_count
    );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Arbitrates the single-port frame buffer RAM between display scan-out and the blur engine.
// Latency: grant combinational in the request cycle; read data valid 3 cycles after the request.
// Backpressure: display loses only on a forced blur slot (dropped, disp_miss); blur engine holds until proc_gnt.
module frame_mem_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 24,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    frame_mem_arbiter_if.slave        bus
);

    typedef enum logic [0:0] {DISP_PRI, PROC_FORCE} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_PROC} tag_t;

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t            state_q;
    logic [3:0]        wait_cnt_q;
    logic              disp_gnt;
    logic              proc_gnt;
    logic              disp_miss;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    tag_t              tag1_q;
    tag_t              tag2_q;
    tag_t              tag1_d;

    logic              disp_valid_q;
    logic [DATA_W-1:0] disp_data_q;
    logic              proc_rvalid_q;
    logic [DATA_W-1:0] proc_rdata_q;

    logic [CNT_W-1:0]  miss_cnt_q;
    logic [CNT_W-1:0]  miss_cnt_d;

    // Grant selection: display first, blur engine first once it has been starved.
    // Grants are suppressed while reset is held so every output reads 0.
    always_comb begin
        disp_gnt = 1'b0;
        proc_gnt = 1'b0;
        if (!rst) begin
            if (state_q == PROC_FORCE) begin
                proc_gnt = bus.proc_req;
                disp_gnt = bus.disp_req & ~bus.proc_req;
            end else begin
                disp_gnt = bus.disp_req;
                proc_gnt = bus.proc_req & ~bus.disp_req;
            end
        end
    end

    assign disp_miss = bus.disp_req & ~disp_gnt & ~rst;

    // Starvation FSM: count consecutive blur denials, force one blur slot after MAX_WAIT of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DISP_PRI;
            wait_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                DISP_PRI: begin
                    if (proc_gnt) begin
                        wait_cnt_q <= 4'd0;
                    end else if (bus.proc_req) begin
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_q    <= PROC_FORCE;
                            wait_cnt_q <= 4'd0;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 4'd1;
                        end
                    end
                end
                PROC_FORCE: begin
                    // Either the forced grant happened or the request went away; both end the slot.
                    state_q    <= DISP_PRI;
                    wait_cnt_q <= 4'd0;
                end
                default: begin
                    state_q    <= DISP_PRI;
                    wait_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    // Tag for the access being issued this cycle; writes never return data.
    always_comb begin
        tag1_d = TAG_NONE;
        if (disp_gnt) begin
            tag1_d = TAG_DISP;
        end else if (proc_gnt && !bus.proc_we) begin
            tag1_d = TAG_PROC;
        end
    end

    // RAM command register plus the two-stage tag pipe that tracks reads in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
        end else begin
            mem_en_q <= disp_gnt | proc_gnt;
            mem_we_q <= proc_gnt & bus.proc_we;
            if (disp_gnt) begin
                mem_addr_q <= bus.disp_addr;
            end else if (proc_gnt) begin
                mem_addr_q  <= bus.proc_addr;
                mem_wdata_q <= bus.proc_wdata;
            end
            tag1_q <= tag1_d;
            tag2_q <= tag1_q;
        end
    end

    // Return path: capture RAM data for whichever master owns the read arriving now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_valid_q  <= 1'b0;
            disp_data_q   <= '0;
            proc_rvalid_q <= 1'b0;
            proc_rdata_q  <= '0;
        end else begin
            disp_valid_q  <= (tag2_q == TAG_DISP);
            proc_rvalid_q <= (tag2_q == TAG_PROC);
            if (tag2_q == TAG_DISP) begin
                disp_data_q <= bus.mem_rdata;
            end
            if (tag2_q == TAG_PROC) begin
                proc_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign miss_cnt_d = (disp_miss && (miss_cnt_q != {CNT_W{1'b1}})) ? miss_cnt_q + 1'b1 : miss_cnt_q;

    // Saturating display-miss counter, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.proc_gnt    = proc_gnt;
    assign bus.disp_miss   = disp_miss;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.disp_valid  = disp_valid_q;
    assign bus.disp_data   = disp_data_q;
    assign bus.proc_rvalid = proc_rvalid_q;
    assign bus.proc_rdata  = proc_rdata_q;
    assign bus.miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Drives both masters against a behavioural RAM and checks every cycle against a reference model.
// Latency: checks grants in the request cycle and read returns three cycles later.
// Backpressure: the blur master holds its request until it sees proc_gnt.
module tb_frame_mem_arbiter;

    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 24;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 16;

    typedef struct {
        int               tag;   // 0 none, 1 display, 2 blur engine
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              d_req  = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic              p_req  = 1'b0;
    logic              p_we   = 1'b0;
    logic [ADDR_W-1:0] p_addr = '0;
    logic [DATA_W-1:0] p_wd   = '0;
    logic [DATA_W-1:0] mem_rdata_r;

    frame_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    frame_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.disp_req   = d_req;
    assign bus.disp_addr  = d_addr;
    assign bus.proc_req   = p_req;
    assign bus.proc_we    = p_we;
    assign bus.proc_addr  = p_addr;
    assign bus.proc_wdata = p_wd;
    assign bus.mem_rdata  = mem_rdata_r;

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_pix(int a);
        return DATA_W'(a * 40503) ^ 24'hA5C3E1;
    endfunction

    // Behavioural synchronous single-port RAM; unwritten words hold a known pattern.
    logic [DATA_W-1:0] ram     [0:(1<<ADDR_W)-1];
    bit                written [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr]     <= bus.mem_wdata;
                written[bus.mem_addr] <= 1'b1;
            end else begin
                mem_rdata_r <= written[bus.mem_addr] ? ram[bus.mem_addr] : init_pix(int'(bus.mem_addr));
            end
        end
    end

    // Reference model state
    int                errors = 0;
    int                checks = 0;
    int                denials = 0;
    int                m_misses = 0;
    logic              x_en = 1'b0, x_we = 1'b0;
    logic [ADDR_W-1:0] x_addr = '0;
    logic [DATA_W-1:0] x_wdata = '0;
    logic [DATA_W-1:0] shadow [int];
    exp_t              pipe [$];
    logic              obs_pgnt;
    int                we_pulses;
    logic [DATA_W-1:0] last_prdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] frame_word(int a);
        return shadow.exists(a) ? shadow[a] : init_pix(a);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   bus.proc_gnt, 0);
        chk({tag, "_miss"},  bus.disp_miss, 0);
        chk({tag, "_en"},    bus.mem_en, 0);
        chk({tag, "_we"},    bus.mem_we, 0);
        chk({tag, "_addr"},  bus.mem_addr, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_dval"},  bus.disp_valid, 0);
        chk({tag, "_ddat"},  bus.disp_data, 0);
        chk({tag, "_pval"},  bus.proc_rvalid, 0);
        chk({tag, "_pdat"},  bus.proc_rdata, 0);
        chk({tag, "_mcnt"},  bus.miss_count, 0);
    endtask

    // One clock cycle: inputs are already applied; check outputs mid-cycle, then advance the model.
    task automatic cyc();
        exp_t e;
        logic m_pgnt, m_dgnt;
        @(negedge clk);
        m_pgnt = p_req && (denials >= MAX_WAIT || !d_req);
        m_dgnt = d_req && !m_pgnt;
        chk("proc_gnt", bus.proc_gnt, m_pgnt);
        chk("disp_miss", bus.disp_miss, d_req && !m_dgnt);
        chk("mem_en", bus.mem_en, x_en);
        chk("mem_we", bus.mem_we, x_we);
        if (x_en) chk("mem_addr", bus.mem_addr, x_addr);
        if (x_we) chk("mem_wdata", bus.mem_wdata, x_wdata);
        chk("miss_count", bus.miss_count, m_misses);
        e.tag = 0;
        e.data = '0;
        if (pipe.size() == 3) e = pipe.pop_front();
        chk("disp_valid", bus.disp_valid, e.tag == 1);
        chk("proc_rvalid", bus.proc_rvalid, e.tag == 2);
        if (e.tag == 1) chk("disp_data", bus.disp_data, e.data);
        if (e.tag == 2) chk("proc_rdata", bus.proc_rdata, e.data);
        if (bus.proc_rvalid) last_prdata = bus.proc_rdata;
        if (bus.mem_we) we_pulses++;
        obs_pgnt = bus.proc_gnt;

        // Advance the reference: what gets issued, what comes back, who was starved.
        x_en = m_dgnt || m_pgnt;
        x_we = m_pgnt && p_we;
        if (m_dgnt) x_addr = d_addr;
        else if (m_pgnt) x_addr = p_addr;
        if (x_we) x_wdata = p_wd;
        e.tag = 0;
        e.data = '0;
        if (m_dgnt) begin
            e.tag = 1;
            e.data = frame_word(int'(d_addr));
        end else if (m_pgnt && !p_we) begin
            e.tag = 2;
            e.data = frame_word(int'(p_addr));
        end
        pipe.push_back(e);
        if (m_pgnt && p_we) shadow[int'(p_addr)] = p_wd;
        if (m_pgnt) denials = 0;
        else if (p_req) denials++;
        else if (denials >= MAX_WAIT) denials = 0;
        if (d_req && !m_dgnt && m_misses < (1 << CNT_W) - 1) m_misses++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        d_req = 1'b0;
        p_req = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int n;
        int k;
        // Reset state, with both requests high to confirm grants are held off.
        d_req = 1'b1;
        p_req = 1'b1;
        #12;
        chk_all_zero("reset");
        d_req = 1'b0;
        p_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: consecutive display reads
        for (int i = 0; i < 10; i++) begin
            d_req  = 1'b1;
            d_addr = ADDR_W'(i);
            cyc();
        end
        idle(4);

        // T2: lone blur read
        p_req  = 1'b1;
        p_we   = 1'b0;
        p_addr = 15'h0079;
        cyc();
        chk("t2_gnt_same_cycle", obs_pgnt, 1);
        idle(4);

        // T3: starvation forcing
        d_req  = 1'b1;
        d_addr = 15'h0050;
        p_req  = 1'b1;
        p_we   = 1'b0;
        p_addr = 15'h0200;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!obs_pgnt && n < 12);
        chk("t3_grant_cycle", n, 5);
        idle(1);
        chk("t3_miss_count", bus.miss_count, 1);
        idle(3);

        // T4: write then read back-to-back
        we_pulses   = 0;
        last_prdata = '0;
        p_req  = 1'b1;
        p_we   = 1'b1;
        p_addr = 15'h0100;
        p_wd   = 24'hFF8040;
        cyc();
        p_we   = 1'b0;
        cyc();
        idle(4);
        chk("t4_rdata", last_prdata, 24'hFF8040);
        chk("t4_we_pulses", we_pulses, 1);

        // T5: interleaved display and blur reads every cycle
        k = 0;
        for (int i = 0; i < 24; i++) begin
            d_req  = (i % 2 == 0);
            d_addr = ADDR_W'(16'h0300 + i);
            p_req  = 1'b1;
            p_we   = 1'b0;
            p_addr = ADDR_W'(16'h0400 + k);
            cyc();
            if (obs_pgnt) k++;
        end
        idle(4);

        // Random traffic on a small address window so writes and reads collide
        for (int i = 0; i < 400; i++) begin
            d_req  = ($urandom_range(0, 3) != 0);
            d_addr = ADDR_W'($urandom_range(0, 15));
            if (!p_req && $urandom_range(0, 2) == 0) begin
                p_req  = 1'b1;
                p_we   = $urandom_range(0, 1) == 1;
                p_addr = ADDR_W'($urandom_range(0, 15));
                p_wd   = DATA_W'($urandom);
            end
            cyc();
            if (obs_pgnt) p_req = 1'b0;
        end
        idle(4);

        // T6: reset with two reads in flight
        d_req  = 1'b1;
        d_addr = 15'h0007;
        cyc();
        d_addr = 15'h0008;
        cyc();
        p_req = 1'b1;
        p_we  = 1'b0;
        rst   = 1'b1;
        #1;
        chk_all_zero("t6_rst");
        pipe.delete();
        x_en = 1'b0;
        x_we = 1'b0;
        x_addr = '0;
        x_wdata = '0;
        denials = 0;
        m_misses = 0;
        d_req = 1'b0;
        p_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        chk("t6_miss_count", bus.miss_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
